// File: rtl/shared_pkg.sv
// Shared types and constants for the SPI RAM controller: command encoding,
// read-response tag, per-pointer arming state and bus widths.
package shared_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned RX_W   = 10;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } spi_cmd_e;

    localparam logic [1:0] TX_TAG = 2'b11;

    // A pointer becomes usable only after its address command has been seen.
    typedef enum logic {
        ST_UNARMED = 1'b0,
        ST_ARMED   = 1'b1
    } arm_state_e;

endpackage

// File: rtl/spi_ram_array.sv
// Byte-wide register array with one synchronous write port and one
// combinational read port. Contents are never reset.
//   clk      : write clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write byte
//   i_raddr  : read address
//   o_rdata_c: read byte (combinational)
module spi_ram_array
    import shared_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_SIZE-1:0] i_waddr,
    input  logic [DATA_W-1:0]    i_wdata,
    input  logic [ADDR_SIZE-1:0] i_raddr,
    output logic [DATA_W-1:0]    o_rdata_c
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port
    assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/spi_ram_ctrl_sva.sv
// Protocol assertions for spi_ram_ctrl, attached by bind: pulses trace back to
// a qualifying command, tx_valid/err exclusion, reset values, pointer advance.
//   clk, rst           : design clock and reset
//   rx_valid, rx_cmd   : qualifier and command bits of the incoming word
//   tx_data, tx_valid, err, wr_addr_q, rd_addr_q : design outputs
//   wr_armed, rd_armed : internal arming states
module spi_ram_ctrl_sva
    import shared_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 8
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 rx_valid,
    input logic [1:0]           rx_cmd,
    input logic [RX_W-1:0]      tx_data,
    input logic                 tx_valid,
    input logic                 err,
    input logic [ADDR_SIZE-1:0] wr_addr_q,
    input logic [ADDR_SIZE-1:0] rd_addr_q,
    input logic                 wr_armed,
    input logic                 rd_armed
);

    logic w_rd_ok, w_rd_bad, w_wr_ok, w_wr_bad;

    assign w_rd_ok  = rx_valid && (rx_cmd == 2'(CMD_RD_DATA)) &&  rd_armed;
    assign w_rd_bad = rx_valid && (rx_cmd == 2'(CMD_RD_DATA)) && !rd_armed;
    assign w_wr_ok  = rx_valid && (rx_cmd == 2'(CMD_WR_DATA)) &&  wr_armed;
    assign w_wr_bad = rx_valid && (rx_cmd == 2'(CMD_WR_DATA)) && !wr_armed;

    // Each pulse cycle is caused by exactly one command in the previous cycle.
    a_tx_pulse: assert property (@(posedge clk) disable iff (rst)
        tx_valid |-> $past(w_rd_ok));
    a_err_pulse: assert property (@(posedge clk) disable iff (rst)
        err |-> $past(w_rd_bad || w_wr_bad));
    a_excl: assert property (@(posedge clk) !(tx_valid && err));

    a_rst_vals: assert property (@(posedge clk) (rst && $past(rst)) |->
        (tx_data == '0 && !tx_valid && !err && wr_addr_q == '0 && rd_addr_q == '0
         && !wr_armed && !rd_armed));

    a_wr_inc: assert property (@(posedge clk) disable iff (rst)
        $past(w_wr_ok) |-> (wr_addr_q == ADDR_SIZE'($past(wr_addr_q) + 1'b1)));
    a_rd_inc: assert property (@(posedge clk) disable iff (rst)
        $past(w_rd_ok) |-> (rd_addr_q == ADDR_SIZE'($past(rd_addr_q) + 1'b1)));

endmodule

bind spi_ram_ctrl spi_ram_ctrl_sva #(
    .ADDR_SIZE (ADDR_SIZE)
) u_sva (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_cmd    (rx_data[9:8]),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .err       (err),
    .wr_addr_q (wr_addr_q),
    .rd_addr_q (rd_addr_q),
    .wr_armed  (r_wr_st == ST_ARMED),
    .rd_armed  (r_rd_st == ST_ARMED)
);

// File: rtl/spi_ram_ctrl.sv
// Command decoder and memory controller behind the SPI slave. Each qualified
// 10-bit word carries a 2-bit command and an 8-bit payload; write/read
// pointers auto-increment so bytes can be burst without resending addresses.
//   clk, rst            : clock, asynchronous active-high reset
//   rx_data, rx_valid   : command word from the SPI slave
//   tx_data, tx_valid   : read response {TX_TAG, byte}, one-cycle valid
//   err                 : one-cycle pulse on a data command to an unarmed pointer
//   wr_addr_q, rd_addr_q: current pointers (observability)
module spi_ram_ctrl
    import shared_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RX_W-1:0]      rx_data,
    input  logic                 rx_valid,
    output logic [RX_W-1:0]      tx_data,
    output logic                 tx_valid,
    output logic                 err,
    output logic [ADDR_SIZE-1:0] wr_addr_q,
    output logic [ADDR_SIZE-1:0] rd_addr_q
);

    // MEM_DEPTH == 2**ADDR_SIZE, so natural pointer overflow is the wrap.
    localparam logic [ADDR_SIZE-1:0] ADDR_ONE = ADDR_SIZE'(1);

    spi_cmd_e               w_cmd;
    logic [DATA_W-1:0]      w_pl;
    logic [ADDR_SIZE-1:0]   w_addr;
    logic                   w_we;
    logic [DATA_W-1:0]      w_rdata;

    logic [RX_W-1:0]        r_tx_data;
    logic                   r_tx_valid;
    logic                   r_err;
    logic [ADDR_SIZE-1:0]   r_wr_addr;
    logic [ADDR_SIZE-1:0]   r_rd_addr;
    arm_state_e             r_wr_st;
    arm_state_e             r_rd_st;

    assign w_cmd  = spi_cmd_e'(rx_data[RX_W-1:DATA_W]);
    assign w_pl   = rx_data[DATA_W-1:0];
    assign w_addr = w_pl[ADDR_SIZE-1:0];

    // The array writes at the current pointer on the same edge the pointer advances.
    assign w_we = rx_valid && (w_cmd == CMD_WR_DATA) && (r_wr_st == ST_ARMED);

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk       (clk),
        .i_we      (w_we),
        .i_waddr   (r_wr_addr),
        .i_wdata   (w_pl),
        .i_raddr   (r_rd_addr),
        .o_rdata_c (w_rdata)
    );

    // Decoder, pointer state machines and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_err      <= 1'b0;
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_wr_st    <= ST_UNARMED;
            r_rd_st    <= ST_UNARMED;
        end else begin
            r_tx_valid <= 1'b0;
            r_err      <= 1'b0;
            if (rx_valid) begin
                case (w_cmd)
                    CMD_WR_ADDR: begin
                        r_wr_addr <= w_addr;
                        r_wr_st   <= ST_ARMED;
                    end
                    CMD_WR_DATA: begin
                        if (r_wr_st == ST_ARMED) begin
                            r_wr_addr <= r_wr_addr + ADDR_ONE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    CMD_RD_ADDR: begin
                        r_rd_addr <= w_addr;
                        r_rd_st   <= ST_ARMED;
                    end
                    CMD_RD_DATA: begin
                        if (r_rd_st == ST_ARMED) begin
                            r_tx_data  <= {TX_TAG, w_rdata};
                            r_tx_valid <= 1'b1;
                            r_rd_addr  <= r_rd_addr + ADDR_ONE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign err       = r_err;
    assign wr_addr_q = r_wr_addr;
    assign rd_addr_q = r_rd_addr;

endmodule
